branch_predictor: RTL and testbench

Fetch-side branch predictor that consumes resolved branch outcomes, i.e. the branch_taken result from the execute-stage comparator. It holds a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB). Fetch queries it each cycle for a taken/target prediction. Execute writes back the resolution, and the block updates its state and maintains branch and mispredict statistics.

---
 rtl/branch_predictor_if.sv | 33 +++
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch query, execute resolution and statistics bundle
// for the branch predictor.
interface branch_predictor_if #(
  parameter int REG_WIDTH = 64
);
  logic [REG_WIDTH-1:0] fetch_pc;
  logic                 pred_taken;
  logic [REG_WIDTH-1:0] pred_target;
  logic                 upd_valid;
  logic [REG_WIDTH-1:0] upd_pc;
  logic                 upd_taken;
  logic [REG_WIDTH-1:0] upd_target;
  logic                 upd_pred_taken;
  logic [REG_WIDTH-1:0] upd_pred_target;
  logic                 ready;
  logic                 mispredict;
  logic [31:0]          br_count;
  logic [31:0]          mp_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken,
    output upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, ready, mispredict,
    input  br_count, mp_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken,
    input  upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, ready, mispredict,
    output br_count, mp_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter table plus tagged BTB,
// swept to a weakly-not-taken state after every reset.
module branch_predictor #(
  parameter int REG_WIDTH  = 64,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input logic              clk,
  input logic              rst_n,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TLO     = INDEX_BITS + 2;
  localparam int THI     = INDEX_BITS + TAG_BITS + 1;

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic                  ready_q, ready_d;
  logic [31:0]           br_q, br_d;
  logic [31:0]           mp_q, mp_d;

  logic [1:0]           cnt_q [ENTRIES];
  logic                 vld_q [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q [ENTRIES];
  logic [REG_WIDTH-1:0] tgt_q [ENTRIES];

  logic                  we, wbtb, wvld;
  logic [INDEX_BITS-1:0] widx;
  logic [1:0]            wcnt;
  logic [TAG_BITS-1:0]   wtag;
  logic [REG_WIDTH-1:0]  wtgt;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  hit, pt, acc, mp;
  logic [1:0]            ucnt;
  logic                  unused_bits;

  assign f_idx = bus.fetch_pc[INDEX_BITS+1:2];
  assign f_tag = bus.fetch_pc[THI:TLO];
  assign u_idx = bus.upd_pc[INDEX_BITS+1:2];
  assign u_tag = bus.upd_pc[THI:TLO];

  assign unused_bits = ^{bus.fetch_pc[1:0],
                         bus.fetch_pc[REG_WIDTH-1:THI+1],
                         bus.upd_pc[1:0],
                         bus.upd_pc[REG_WIDTH-1:THI+1]};

  // Prediction reads the table as it stands; no update bypass.
  assign hit = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pt  = ready_q & cnt_q[f_idx][1] & hit;

  assign bus.pred_taken  = pt;
  assign bus.pred_target = pt ? tgt_q[f_idx]
                              : bus.fetch_pc + REG_WIDTH'(4);

  assign acc  = bus.upd_valid & ready_q;
  assign ucnt = cnt_q[u_idx];
  assign mp   = acc &
    ((bus.upd_taken != bus.upd_pred_taken) |
     (bus.upd_taken & bus.upd_pred_taken &
      (bus.upd_target != bus.upd_pred_target)));

  assign bus.mispredict = mp;
  assign bus.ready      = ready_q;
  assign bus.br_count   = br_q;
  assign bus.mp_count   = mp_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    br_d    = br_q;
    mp_d    = mp_q;
    we      = 1'b0;
    wbtb    = 1'b0;
    wvld    = 1'b0;
    widx    = '0;
    wcnt    = 2'b01;
    wtag    = '0;
    wtgt    = '0;
    unique case (state_q)
      INIT: begin
        we    = 1'b1;
        wbtb  = 1'b1;
        widx  = ptr_q;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {INDEX_BITS{1'b1}}) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (acc) begin
          we   = 1'b1;
          widx = u_idx;
          wbtb = bus.upd_taken;
          wvld = 1'b1;
          wtag = u_tag;
          wtgt = bus.upd_target;
          if (bus.upd_taken)
            wcnt = (ucnt == 2'b11) ? ucnt : ucnt + 2'b01;
          else
            wcnt = (ucnt == 2'b00) ? ucnt : ucnt - 2'b01;
          br_d = br_q + 32'd1;
          if (mp)
            mp_d = mp_q + 32'd1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      br_q    <= '0;
      mp_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
    end
  end

  // Table contents are defined by the sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      cnt_q[widx] <= wcnt;
      if (wbtb) begin
        vld_q[widx] <= wvld;
        tag_q[widx] <= wtag;
        tgt_q[widx] <= wtgt;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor.
// Expectations are queued per cycle and checked at negedge.
module tb_branch_predictor;

  localparam int F_RDY = 0;
  localparam int F_PT  = 1;
  localparam int F_TGT = 2;
  localparam int F_MP  = 3;
  localparam int F_BR  = 4;
  localparam int F_MPC = 5;

  typedef struct {
    int          cyc;
    int          fld;
    logic [63:0] exp;
    string       name;
  } item_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  item_t sb[$];

  branch_predictor_if #(.REG_WIDTH(64)) bus();

  branch_predictor #(
    .REG_WIDTH(64),
    .INDEX_BITS(6),
    .TAG_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] actual(int f);
    case (f)
      F_RDY:   return 64'(bus.ready);
      F_PT:    return 64'(bus.pred_taken);
      F_TGT:   return bus.pred_target;
      F_MP:    return 64'(bus.mispredict);
      F_BR:    return 64'(bus.br_count);
      default: return 64'(bus.mp_count);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item_t it;
      logic [63:0] a;
      it = sb.pop_front();
      a  = actual(it.fld);
      checks++;
      if (it.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale check from cycle %0d at %0d",
                 it.name, it.cyc, cyc);
      end else if (a !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h",
                 it.name, a, it.exp);
      end
    end
  end

  task automatic expect_v(int f, logic [63:0] v, string n);
    item_t it;
    it.cyc  = cyc;
    it.fld  = f;
    it.exp  = v;
    it.name = n;
    sb.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic upd(logic [63:0] pc, logic t,
                     logic [63:0] tgt, logic pt,
                     logic [63:0] ptgt);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = t;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = pt;
    bus.upd_pred_target = ptgt;
  endtask

  task automatic pred(logic [63:0] fpc, logic pt,
                      logic [63:0] tgt, string n);
    bus.fetch_pc = fpc;
    expect_v(F_PT,  64'(pt), {n, "_pt"});
    expect_v(F_TGT, tgt,     {n, "_tgt"});
  endtask

  task automatic stats(int br, int mp, string n);
    expect_v(F_BR,  64'(br), {n, "_br"});
    expect_v(F_MPC, 64'(mp), {n, "_mpc"});
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.fetch_pc        = 64'h1000;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = '0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = '0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = '0;
    tick();

    // Reset and initial sweep
    expect_v(F_RDY, 0, "rst_ready");
    stats(0, 0, "rst");
    pred(64'h1000, 0, 64'h1004, "rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      expect_v(F_RDY, 0, "init_ready");
      pred(64'h1000, 0, 64'h1004, "init");
      tick();
    end
    expect_v(F_RDY, 1, "run_ready");
    stats(0, 0, "run");

    // Two taken updates from weakly-not-taken
    pred(64'h1000, 0, 64'h1004, "s2a");
    upd(64'h1000, 1, 64'h2000, 0, 64'h1004);
    expect_v(F_MP, 1, "s2a_mp");
    tick();
    pred(64'h1000, 1, 64'h2000, "s2b");
    stats(1, 1, "s2b");
    upd(64'h1000, 1, 64'h2000, 0, 64'h1004);
    expect_v(F_MP, 1, "s2b_mp");
    tick();
    stats(2, 2, "s2c");

    // Saturate high, then step down once
    for (int i = 0; i < 5; i++) begin
      pred(64'h1000, 1, 64'h2000, "s3sat");
      upd(64'h1000, 1, 64'h2000, 1, 64'h2000);
      expect_v(F_MP, 0, "s3sat_mp");
      tick();
    end
    stats(7, 2, "s3a");
    pred(64'h1000, 1, 64'h2000, "s3nt");
    upd(64'h1000, 0, 64'h2000, 1, 64'h2000);
    expect_v(F_MP, 1, "s3nt_mp");
    tick();
    pred(64'h1000, 1, 64'h2000, "s3b");
    stats(8, 3, "s3b");
    tick();

    // Alias at same index with a different tag
    pred(64'h1100, 0, 64'h1104, "s4a");
    upd(64'h1100, 1, 64'h3000, 0, 64'h1104);
    expect_v(F_MP, 1, "s4a_mp");
    tick();
    pred(64'h1000, 0, 64'h1004, "s4evict");
    stats(9, 4, "s4b");
    tick();
    pred(64'h1100, 1, 64'h3000, "s4new");

    // Saturate low from cnt=3
    for (int i = 0; i < 4; i++) begin
      upd(64'h1100, 0, 64'h3000, 0, 64'h1104);
      expect_v(F_MP, 0, "s4dn_mp");
      tick();
    end
    pred(64'h1100, 0, 64'h1104, "s4zero");
    stats(13, 4, "s4c");
    upd(64'h1100, 1, 64'h3000, 0, 64'h1104);
    expect_v(F_MP, 1, "s4up_mp");
    tick();
    pred(64'h1100, 0, 64'h1104, "s4one");
    stats(14, 5, "s4d");
    tick();

    // Same-cycle predict and update, no bypass
    pred(64'h1040, 0, 64'h1044, "s5same");
    upd(64'h1040, 1, 64'h4000, 0, 64'h1044);
    expect_v(F_MP, 1, "s5a_mp");
    tick();
    pred(64'h1040, 1, 64'h4000, "s5next");
    stats(15, 6, "s5b");
    upd(64'h1040, 1, 64'h4000, 1, 64'h5000);
    expect_v(F_MP, 1, "s5tgt_mp");
    tick();
    stats(16, 7, "s5c");
    upd(64'h1040, 1, 64'h4000, 1, 64'h4000);
    expect_v(F_MP, 0, "s5ok_mp");
    tick();
    stats(17, 7, "s5d");
    tick();

    // Reset mid-run, updates ignored during sweep
    rst_n = 1'b0;
    expect_v(F_RDY, 0, "rst2_ready");
    stats(0, 0, "rst2");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      upd(64'h1040, 1, 64'h9000, 0, 64'h1044);
      expect_v(F_RDY, 0, "init2_ready");
      expect_v(F_MP, 0, "init2_mp");
      pred(64'h1040, 0, 64'h1044, "init2");
      tick();
    end
    expect_v(F_RDY, 1, "run2_ready");
    stats(0, 0, "run2");
    pred(64'h1040, 0, 64'h1044, "run2");
    tick();
    pred(64'h1000, 0, 64'h1004, "run2old");
    upd(64'h1000, 1, 64'h2000, 0, 64'h1004);
    expect_v(F_MP, 1, "run2_mp");
    tick();
    stats(1, 1, "run2b");
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
